// File: rtl/instr_mem_prog_if.sv
// Load stream and dual-word fetch bundle for the field-loadable instruction memory.
interface instr_mem_prog_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data0;
  logic [DATA_W-1:0] fetch_data1;
  logic              fetch_oob;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_done, prog_len, busy,
           fetch_valid, fetch_data0, fetch_data1, fetch_oob
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_done, prog_len, busy,
           fetch_valid, fetch_data0, fetch_data1, fetch_oob
  );
endinterface

// File: rtl/instr_mem_prog.sv
// Instruction memory loaded over a valid/ready stream, with a registered
// dual-word fetch (addr, addr+1 mod DEPTH) that masks words past the program end.
module instr_mem_prog #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_prog_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, w_wptr_nxt;
  logic [ADDR_W:0]   r_prog_len, w_prog_len_nxt;
  logic              r_done_p1, w_done_nxt;
  logic              w_load_ready;
  logic              w_accept;
  logic              w_final;
  logic              w_fetch_acc_p0;
  logic [ADDR_W-1:0] w_addr0_p0, w_addr1_p0;
  logic              w_in0_p0, w_in1_p0;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data0_p1, r_data1_p1;
  logic              r_oob_p1;

  function automatic logic in_prog(input logic [ADDR_W-1:0] idx,
                                   input logic [ADDR_W:0]   len);
    return {1'b0, idx} < len;
  endfunction

  function automatic logic [DATA_W-1:0] mask_word(input logic [DATA_W-1:0] word,
                                                  input logic              keep);
    return keep ? word : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_prog_len <= '0;
      r_done_p1  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_prog_len <= w_prog_len_nxt;
      r_done_p1  <= w_done_nxt;
    end
  end

  // load_start always wins: it restarts the load and blocks both the load word
  // and any fetch offered in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_prog_len_nxt = r_prog_len;
    w_done_nxt     = 1'b0;
    w_load_ready   = (r_state == S_LOAD) && !bus.load_start;
    w_accept       = w_load_ready && bus.load_valid;
    w_final        = w_accept && (bus.load_last || (r_wptr == '1));
    w_fetch_acc_p0 = (r_state == S_READY) && bus.fetch_req && !bus.load_start;
    if (bus.load_start) begin
      w_state_nxt    = S_LOAD;
      w_wptr_nxt     = '0;
      w_prog_len_nxt = '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            w_wptr_nxt = r_wptr + ADDR_W'(1);
            if (w_final) begin
              w_state_nxt    = S_READY;
              w_prog_len_nxt = {1'b0, r_wptr} + (ADDR_W + 1)'(1);
              w_done_nxt     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; prog_len masks stale contents.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= bus.load_data;
  end

  // Stage p0 -> p1: fetch request to registered dual-word response
  assign w_addr0_p0 = bus.fetch_addr;
  assign w_addr1_p0 = bus.fetch_addr + ADDR_W'(1);
  assign w_in0_p0   = in_prog(w_addr0_p0, r_prog_len);
  assign w_in1_p0   = in_prog(w_addr1_p0, r_prog_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_data0_p1 <= '0;
      r_data1_p1 <= '0;
      r_oob_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_fetch_acc_p0;
      if (w_fetch_acc_p0) begin
        r_data0_p1 <= mask_word(r_mem[w_addr0_p0], w_in0_p0);
        r_data1_p1 <= mask_word(r_mem[w_addr1_p0], w_in1_p0);
        r_oob_p1   <= !(w_in0_p0 && w_in1_p0);
      end
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.load_done   = r_done_p1;
  assign bus.prog_len    = r_prog_len;
  assign bus.busy        = (r_state == S_LOAD);
  assign bus.fetch_valid = r_vld_p1;
  assign bus.fetch_data0 = r_data0_p1;
  assign bus.fetch_data1 = r_data1_p1;
  assign bus.fetch_oob   = r_oob_p1;
endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: program-level model checked every cycle plus literal expectations.
module tb_instr_mem_prog;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  instr_mem_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  instr_mem_prog #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Program-level model: a load session, a word list and its length.
  bit          m_loading = 0;
  bit          m_have_prog = 0;
  int          m_count = 0;
  int          m_len = 0;
  logic [15:0] m_mem [DEPTH];
  bit          m_done = 0;
  bit          m_fv = 0;
  logic [15:0] m_d0 = '0;
  logic [15:0] m_d1 = '0;
  bit          m_oob = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_have_prog = 0; m_count = 0; m_len = 0;
      m_done = 0; m_fv = 0; m_d0 = '0; m_d1 = '0; m_oob = 0;
    end else begin
      m_done = 0;
      m_fv = 0;
      if (bus.load_start) begin
        m_loading = 1; m_have_prog = 0; m_count = 0; m_len = 0;
      end else if (m_loading && bus.load_valid) begin
        m_mem[m_count] = bus.load_data;
        m_count++;
        if (bus.load_last || m_count == DEPTH) begin
          m_loading = 0; m_have_prog = 1; m_len = m_count; m_done = 1;
        end
      end else if (m_have_prog && bus.fetch_req) begin
        int a0, a1;
        a0 = int'(bus.fetch_addr);
        a1 = (a0 + 1) % DEPTH;
        m_d0 = (a0 < m_len) ? m_mem[a0] : 16'h0;
        m_d1 = (a1 < m_len) ? m_mem[a1] : 16'h0;
        m_oob = (a0 >= m_len) || (a1 >= m_len);
        m_fv = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("load_ready", 32'(bus.load_ready), 32'(m_loading && !bus.load_start));
    chk("busy", 32'(bus.busy), 32'(m_loading));
    chk("load_done", 32'(bus.load_done), 32'(m_done));
    chk("prog_len", 32'(bus.prog_len), 32'(m_len));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
    chk("fetch_data0", 32'(bus.fetch_data0), 32'(m_d0));
    chk("fetch_data1", 32'(bus.fetch_data1), 32'(m_d1));
    chk("fetch_oob", 32'(bus.fetch_oob), 32'(m_oob));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  logic [15:0] exp_run [4] = '{16'hC001, 16'hC002, 16'h0000, 16'h0000};

  initial begin
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prog_len", 32'(bus.prog_len), 32'd0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_data0", 32'(bus.fetch_data0), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1;
    cyc();

    // Three-word program, last flagged on the third word
    bus.load_start = 1; cyc(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 16'h3004; cyc();
    bus.load_data = 16'h3105; cyc();
    bus.load_data = 16'h0000; bus.load_last = 1; cyc();
    bus.load_valid = 0; bus.load_last = 0;
    bus.fetch_req = 1; bus.fetch_addr = 5'd0;
    peek();
    chk("t1_done", 32'(bus.load_done), 32'd1);
    chk("t1_len", 32'(bus.prog_len), 32'd3);
    cyc(); bus.fetch_addr = 5'd2;
    peek();
    chk("t1_a0_vld", 32'(bus.fetch_valid), 32'd1);
    chk("t1_a0_d0", 32'(bus.fetch_data0), 32'h3004);
    chk("t1_a0_d1", 32'(bus.fetch_data1), 32'h3105);
    chk("t1_a0_oob", 32'(bus.fetch_oob), 32'd0);
    chk("t1_done_once", 32'(bus.load_done), 32'd0);
    cyc(); bus.fetch_addr = 5'd5;
    peek();
    chk("t1_a2_d1", 32'(bus.fetch_data1), 32'h0);
    chk("t1_a2_oob", 32'(bus.fetch_oob), 32'd1);
    cyc(); bus.fetch_req = 0;
    peek();
    chk("t1_a5_d0", 32'(bus.fetch_data0), 32'h0);
    chk("t1_a5_oob", 32'(bus.fetch_oob), 32'd1);
    cyc();
    peek();
    chk("t1_idle_vld", 32'(bus.fetch_valid), 32'd0);

    // Full-depth load without load_last, then one extra word offered
    cyc();
    bus.load_start = 1; cyc(); bus.load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_valid = 1; bus.load_data = 16'h1000 + 16'(i); cyc();
    end
    bus.load_data = 16'hBEEF;
    peek();
    chk("t2_ready_low", 32'(bus.load_ready), 32'd0);
    chk("t2_len", 32'(bus.prog_len), 32'd32);
    cyc();
    bus.load_valid = 0; bus.fetch_req = 1; bus.fetch_addr = 5'd31;
    cyc(); bus.fetch_req = 0;
    peek();
    chk("t2_d0", 32'(bus.fetch_data0), 32'h101F);
    chk("t2_d1_wrap", 32'(bus.fetch_data1), 32'h1000);
    chk("t2_oob", 32'(bus.fetch_oob), 32'd0);

    // Gapped load interrupted by load_start with load_valid held high
    cyc();
    bus.load_start = 1; cyc(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 16'hAAAA; cyc();
    bus.load_valid = 0; cyc();
    bus.load_valid = 1; bus.load_data = 16'hBBBB; cyc();
    bus.load_start = 1; bus.load_data = 16'hDEAD;
    peek();
    chk("t3_ready_on_start", 32'(bus.load_ready), 32'd0);
    cyc(); bus.load_start = 0;
    bus.load_data = 16'hC001; cyc();
    bus.load_valid = 0; cyc();
    bus.load_valid = 1; bus.load_data = 16'hC002; bus.load_last = 1; cyc();
    bus.load_valid = 0; bus.load_last = 0;
    bus.fetch_req = 1; bus.fetch_addr = 5'd0;
    peek();
    chk("t3_len", 32'(bus.prog_len), 32'd2);
    cyc(); bus.fetch_addr = 5'd1;
    peek();
    chk("t3_d0", 32'(bus.fetch_data0), 32'hC001);
    chk("t3_d1", 32'(bus.fetch_data1), 32'hC002);
    cyc();
    peek();
    chk("t3_a1_d1", 32'(bus.fetch_data1), 32'h0);
    chk("t3_a1_oob", 32'(bus.fetch_oob), 32'd1);

    // Back-to-back fetches 0..3
    for (int i = 0; i < 4; i++) begin
      bus.fetch_addr = 5'(i);
      cyc();
      peek();
      chk("t4_vld", 32'(bus.fetch_valid), 32'd1);
      chk("t4_d0", 32'(bus.fetch_data0), 32'(exp_run[i]));
    end

    // load_start together with fetch_req: load wins, later fetches ignored in LOAD
    bus.load_start = 1;
    cyc(); bus.load_start = 0;
    peek();
    chk("t5_vld_start", 32'(bus.fetch_valid), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    cyc();
    peek();
    chk("t5_vld_load", 32'(bus.fetch_valid), 32'd0);
    bus.fetch_req = 0;

    // Asynchronous reset after two accepted words
    cyc();
    bus.load_valid = 1; bus.load_data = 16'h5555; cyc();
    bus.load_data = 16'h6666; cyc();
    bus.load_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_len", 32'(bus.prog_len), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_vld", 32'(bus.fetch_valid), 32'd0);
    chk("t6_d0", 32'(bus.fetch_data0), 32'd0);
    @(posedge clk); #2;
    rst_n = 1;
    bus.fetch_req = 1; bus.fetch_addr = 5'd0;
    cyc();
    peek();
    chk("t6_no_fetch", 32'(bus.fetch_valid), 32'd0);
    cyc();
    bus.fetch_req = 0;
    bus.load_start = 1; cyc(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 16'h7777; bus.load_last = 1; cyc();
    bus.load_valid = 0; bus.load_last = 0;
    bus.fetch_req = 1; bus.fetch_addr = 5'd0;
    cyc(); bus.fetch_req = 0;
    peek();
    chk("t6_vld_after", 32'(bus.fetch_valid), 32'd1);
    chk("t6_d0_after", 32'(bus.fetch_data0), 32'h7777);
    chk("t6_d1_masked", 32'(bus.fetch_data1), 32'h0);
    chk("t6_oob", 32'(bus.fetch_oob), 32'd1);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
